alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; SHALL be even and at least 8.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 in_valid  input  1: operation request, sampled only when busy=0.
REQ-006 ALUOp  input  3: 000 add, 001 sub, 011 lui, 100 or, 010 R-type (decode funct); other codes give result 0.
REQ-007 funct  input  6: R-type function field.
REQ-008 a, b  input  WIDTH each: operand A (rs) and operand B (rt or immediate).
REQ-009 shamt  input  SHW: shift amount.
REQ-010 busy  output  1: high while a multiply or divide iterates; upstream SHALL stall.
REQ-011 out_valid  output  1: one-cycle pulse marking result valid.
REQ-012 result  output  WIDTH: registered result.
REQ-013 zero  output  1: registered, equals (result == 0), updated with result.
REQ-014 hi, lo  output  WIDTH each: HI/LO architectural registers.

Function
REQ-015 Decode SHALL support funct values ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010 (signed), SLTU 101011, SLL 000000, SRL 000010, SRA 000011, MFHI 010000, MFLO 010010, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
REQ-016 An unlisted funct SHALL give result 0 and still pulse out_valid.
REQ-017 lui SHALL give b shifted left by WIDTH/2 with zero fill.
REQ-018 Add and sub SHALL wrap modulo 2^WIDTH; no overflow trap or flag.
REQ-019 Shifts SHALL use shamt; SRA SHALL sign-fill from b[WIDTH-1]; the shifted operand SHALL be b.
REQ-020 Single-cycle ops (all except MULT/MULTU/DIV/DIVU): accepted when in_valid=1 and busy=0; result, zero and out_valid=1 SHALL appear on the next edge (latency 1); throughput 1 per cycle.
REQ-021 MFHI/MFLO SHALL return hi/lo as they stand at acceptance.
REQ-022 FSM states: IDLE, MUL, DIV, DONE.
REQ-023 IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; busy SHALL go high on the same edge.
REQ-024 MUL: shift-add, one bit per cycle, exactly WIDTH cycles, then ->DONE.
REQ-025 DIV: restoring division, one quotient bit per cycle, exactly WIDTH cycles, then ->DONE.
REQ-026 Signed MULT/DIV SHALL operate on magnitudes; product and quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
REQ-027 DONE, one cycle: hi/lo written (mult: hi=upper, lo=lower product half; div: hi=remainder, lo=quotient); busy=0; out_valid=1; result=new lo; then ->IDLE.
REQ-028 Accept-to-out_valid latency for MULT/DIV SHALL be WIDTH+1 cycles; a new request may be accepted on the edge leaving DONE.
REQ-029 Divide by zero: hi=a, lo=all ones, normal latency; no trap.
REQ-030 Signed DIV of most-negative by -1: lo=most-negative, hi=0.
REQ-031 in_valid while busy=1 SHALL be ignored; operands are latched at acceptance, so later input changes have no effect.
REQ-032 hi/lo SHALL change only in DONE.
REQ-033 out_valid SHALL be 0 in every cycle without a completion.

Reset
REQ-034 rst_n low SHALL asynchronously force state IDLE, busy=0, out_valid=0, result=0, zero=1, hi=0, lo=0, and clear the iteration counter and partial results.
REQ-035 Reset mid-MUL/DIV SHALL abort the operation; hi/lo SHALL read 0 after reset.
REQ-036 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-037 WIDTH=32, ALUOp=010, funct=SRA, b=0x80000000, shamt=4 -> next cycle result=0xF8000000, out_valid=1, zero=0.
REQ-038 MULT a=-3 (0xFFFFFFFD), b=7 -> busy for 32 cycles; at cycle 33 hi=0xFFFFFFFF, lo=0xFFFFFFEB, result=0xFFFFFFEB, out_valid pulses once.
REQ-039 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then MFHI -> result=0xFFFFFFFF one cycle later.
REQ-040 DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF after 33 cycles; a SUB held on in_valid during busy is executed exactly once, after DONE.
REQ-041 Back-to-back ADD 1+2, SUB 2-2, LUI b=0x1234 on consecutive cycles -> results 3, 0 (zero=1), 0x12340000 on consecutive cycles.
REQ-042 rst_n low at MUL cycle 10 -> busy=0 and hi=lo=0 immediately; no out_valid; a following MFLO returns 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ALU ops plus iterative multiply/divide
// that update the HI/LO register pair.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | accepting requests, single-cycle ops complete here
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | hi/lo/result just written, out_valid high, accepting requests
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    state_t             state, state_nx;
    logic [SHW-1:0]     cnt;
    logic [WIDTH-1:0]   acc_hi, acc_lo, mcand;
    logic               neg_q, neg_r, div0;

    logic               is_r, start_mul, start_div;
    logic               load_op, single, finish;
    logic               op_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, alu_res;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, remd;

    assign is_r      = (ALUOp == 3'b010);
    assign start_mul = is_r && (funct == F_MULT || funct == F_MULTU);
    assign start_div = is_r && (funct == F_DIV  || funct == F_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (in_valid && start_mul)      state_nx = MUL;
                else if (in_valid && start_div) state_nx = DIV;
            end
            MUL, DIV: if (cnt == '0) state_nx = DONE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        load_op = 1'b0;
        single  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE, DONE: begin
                load_op = in_valid & (start_mul | start_div);
                single  = in_valid & ~(start_mul | start_div);
            end
            MUL, DIV: begin
                busy   = 1'b1;
                finish = (cnt == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ALUOp)
            3'b000: alu_res = a + b;
            3'b001: alu_res = a - b;
            3'b011: alu_res = b << (WIDTH / 2);
            3'b100: alu_res = a | b;
            3'b010: begin
                case (funct)
                    F_ADD, F_ADDU: alu_res = a + b;
                    F_SUB, F_SUBU: alu_res = a - b;
                    F_AND:  alu_res = a & b;
                    F_OR:   alu_res = a | b;
                    F_XOR:  alu_res = a ^ b;
                    F_NOR:  alu_res = ~(a | b);
                    F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
                    F_SLL:  alu_res = b << shamt;
                    F_SRL:  alu_res = b >> shamt;
                    F_SRA:  alu_res = $signed(b) >>> shamt;
                    F_MFHI: alu_res = hi;
                    F_MFLO: alu_res = lo;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // MULT and DIV are the even funct codes of their pairs
    assign op_signed = ~funct[0];
    assign a_neg     = op_signed & a[WIDTH-1];
    assign b_neg     = op_signed & b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;

    // acc_lo holds the multiplier (mul) or the dividend being shifted out (div)
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand};
    assign div_hi_nx = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_lo_nx = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};

    assign prod = neg_q ? -{mul_hi_nx, mul_lo_nx} : {mul_hi_nx, mul_lo_nx};
    assign quot = div0 ? '1 : (neg_q ? -div_lo_nx : div_lo_nx);
    assign remd = neg_r ? -div_hi_nx : div_hi_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            if (load_op) begin
                acc_hi <= '0;
                acc_lo <= start_mul ? mag_b : mag_a;
                mcand  <= start_mul ? mag_a : mag_b;
                cnt    <= SHW'(WIDTH - 1);
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                div0   <= (b == '0);
            end else if (busy) begin
                acc_hi <= (state == MUL) ? mul_hi_nx : div_hi_nx;
                acc_lo <= (state == MUL) ? mul_lo_nx : div_lo_nx;
                cnt    <= cnt - SHW'(1);
            end

            if (finish) begin
                out_valid <= 1'b1;
                if (state == MUL) begin
                    hi     <= prod[2*WIDTH-1:WIDTH];
                    lo     <= prod[WIDTH-1:0];
                    result <= prod[WIDTH-1:0];
                    zero   <= (prod[WIDTH-1:0] == '0);
                end else begin
                    hi     <= remd;
                    lo     <= quot;
                    result <= quot;
                    zero   <= (quot == '0);
                end
            end else if (single) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                zero      <= (alu_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (WIDTH=32): scoreboard of expected
// results plus per-scenario checks of timing, hi/lo and reset behaviour.
module tb_alu_exec_unit;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  ALUOp = 3'b000;
    logic [5:0]  funct = 6'b000000;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic        busy, out_valid, zero;
    logic [31:0] result, hi, lo;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUOp(ALUOp),
        .funct(funct), .a(a), .b(b), .shamt(shamt), .busy(busy),
        .out_valid(out_valid), .result(result), .zero(zero), .hi(hi), .lo(lo)
    );

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [5:0] f,
                                              input logic [31:0] x, input logic [31:0] y,
                                              input logic [4:0] sh,
                                              input logic [31:0] h, input logic [31:0] l);
        logic [63:0] ext;
        logic [31:0] r;
        r = 32'h0;
        case (op)
            3'b000: r = x + y;
            3'b001: r = x - y;
            3'b011: r = {y[15:0], 16'h0000};
            3'b100: r = x | y;
            3'b010: begin
                case (f)
                    F_ADD, F_ADDU: r = x + y;
                    F_SUB, F_SUBU: r = x - y;
                    F_AND:  r = x & y;
                    F_OR:   r = x | y;
                    F_XOR:  r = x ^ y;
                    F_NOR:  r = ~(x | y);
                    F_SLT:  r = ((x[31] & ~y[31]) || ((x[31] == y[31]) && (x < y))) ? 32'd1 : 32'd0;
                    F_SLTU: r = (x < y) ? 32'd1 : 32'd0;
                    F_SLL:  r = y << sh;
                    F_SRL:  r = y >> sh;
                    F_SRA: begin
                        ext = {{32{y[31]}}, y} >> sh;
                        r   = ext[31:0];
                    end
                    F_MFHI: r = h;
                    F_MFLO: r = l;
                    default: r = 32'h0;
                endcase
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Present a request and record what it must produce; caller owns the clock edges.
    task automatic drive(input logic [2:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
        logic signed [63:0] sx, sy, sp;
        logic signed [31:0] dx, dy;
        logic [63:0]        up;
        ALUOp = op; funct = f; a = x; b = y; shamt = sh; in_valid = 1'b1;
        if (op == 3'b010 && (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU)) begin
            if (f == F_MULT) begin
                sx = {{32{x[31]}}, x};
                sy = {{32{y[31]}}, y};
                sp = sx * sy;
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end else if (f == F_MULTU) begin
                up = {32'h0, x} * {32'h0, y};
                m_hi = up[63:32]; m_lo = up[31:0];
            end else if (y == 32'h0) begin
                m_hi = x; m_lo = 32'hFFFF_FFFF;
            end else if (f == F_DIV) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    m_hi = 32'h0; m_lo = 32'h8000_0000;
                end else begin
                    dx = x; dy = y;
                    m_lo = dx / dy; m_hi = dx % dy;
                end
            end else begin
                m_lo = x / y; m_hi = x % y;
            end
            exp_q.push_back(m_lo);
        end else begin
            exp_q.push_back(model_alu(op, f, x, y, sh, m_hi, m_lo));
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [5:0] f,
                         input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
        drive(op, f, x, y, sh);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Step negedges until out_valid; cyc=100 means the bound expired.
    task automatic wait_done(output int cyc, output int bcyc);
        cyc = 0; bcyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) bcyc++;
        end while (out_valid !== 1'b1 && cyc < 100);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: result=%h with no result expected (t=%0t)", result, $time);
            end else begin
                e = exp_q.pop_front();
                if (result !== e) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h expected %h (t=%0t)", result, e, $time);
                end
                n_checks++;
                if (zero !== (e == 32'h0)) begin
                    n_fail++;
                    $display("FAIL sb_zero: got %b expected %b (t=%0t)", zero, (e == 32'h0), $time);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result: got %h expected 0", result); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero: got %b expected 1", zero); end
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL rst_hilo: got %h/%h expected 0/0", hi, lo); end
        rst_n = 1'b1;
    endtask

    task automatic test_sra();
        issue(3'b010, F_SRA, 32'h0, 32'h8000_0000, 5'd4);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sra_valid: got %b expected 1", out_valid); end
        n_checks++; if (result !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_result: got %h expected f8000000", result); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sra_zero: got %b expected 0", zero); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(3'b000, 6'h0, 32'd1, 32'd2, 5'd0);
        @(posedge clk); #1;
        drive(3'b001, 6'h0, 32'd2, 32'd2, 5'd0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd3) begin n_fail++; $display("FAIL b2b_add: got v=%b %h expected v=1 00000003", out_valid, result); end
        @(posedge clk); #1;
        drive(3'b011, 6'h0, 32'h0, 32'h0000_1234, 5'd0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin n_fail++; $display("FAIL b2b_sub: got v=%b %h z=%b expected v=1 00000000 z=1", out_valid, result, zero); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result !== 32'h1234_0000) begin n_fail++; $display("FAIL b2b_lui: got v=%b %h expected v=1 12340000", out_valid, result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_alu_random(input int n);
        logic [5:0] flist [17] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                                   F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_MFHI, F_MFLO,
                                   6'b111111, 6'b000001};
        logic [2:0] olist [9] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b010, 3'b010, 3'b010, 3'b101, 3'b111};
        logic [31:0] x, y;
        for (int i = 0; i < n; i++) begin
            x = $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            drive(olist[$urandom_range(0, 8)], flist[$urandom_range(0, 16)], x, y, 5'($urandom_range(0, 31)));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc, bcyc;
        issue(3'b010, F_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0);
        wait_done(cyc, bcyc);
        n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
        n_checks++; if (bcyc !== 32) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 32", bcyc); end
        n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_hilo: got %h/%h expected ffffffff/ffffffeb", hi, lo); end
        n_checks++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_result: got %h expected ffffffeb", result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mult_single_pulse: got v=%b busy=%b expected 0/0", out_valid, busy); end
    endtask

    task automatic test_div_mfhi();
        int cyc, bcyc;
        issue(3'b010, F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0);
        wait_done(cyc, bcyc);
        n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", cyc); end
        n_checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hilo: got %h/%h expected ffffffff/fffffffd", hi, lo); end
        issue(3'b010, F_MFHI, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_mfhi: got v=%b %h expected v=1 ffffffff", out_valid, result); end
    endtask

    task automatic test_divu_zero_stall();
        int cyc, bcyc;
        issue(3'b010, F_DIVU, 32'd5, 32'd0, 5'd0);
        drive(3'b010, F_SUB, 32'd10, 32'd3, 5'd0);
        wait_done(cyc, bcyc);
        n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL divu0_latency: got %0d expected 33", cyc); end
        n_checks++; if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_hilo: got %h/%h expected 00000005/ffffffff", hi, lo); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result !== 32'd7) begin n_fail++; $display("FAIL stalled_sub: got v=%b %h expected v=1 00000007", out_valid, result); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stalled_sub_once: got %b expected 0", out_valid); end
    endtask

    task automatic test_div_overflow();
        int cyc, bcyc;
        issue(3'b010, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        wait_done(cyc, bcyc);
        n_checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf: got %h/%h expected 00000000/80000000", hi, lo); end
    endtask

    task automatic test_muldiv_random(input int n);
        logic [5:0] fl [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [31:0] x, y;
        int cyc, bcyc;
        for (int i = 0; i < n; i++) begin
            x = $urandom;
            y = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            issue(3'b010, fl[i % 4], x, y, 5'd0);
            wait_done(cyc, bcyc);
            n_checks++; if (cyc !== 33) begin n_fail++; $display("FAIL md_latency[%0d]: got %0d expected 33", i, cyc); end
            n_checks++; if (hi !== m_hi || lo !== m_lo) begin n_fail++; $display("FAIL md_hilo[%0d]: got %h/%h expected %h/%h", i, hi, lo, m_hi, m_lo); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, bcyc, seen;
        issue(3'b010, F_MULTU, 32'd3, 32'd5, 5'd0);
        wait_done(cyc, bcyc);
        issue(3'b010, F_MULT, 32'd5, 32'd6, 5'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got busy=%b v=%b expected 0/0", busy, out_valid); end
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL midrst_hilo: got %h/%h expected 0/0", hi, lo); end
        exp_q.delete();
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen); end
        issue(3'b010, F_MFLO, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || result !== 32'h0) begin n_fail++; $display("FAIL midrst_mflo: got v=%b %h expected v=1 00000000", out_valid, result); end
    endtask

    initial begin
        test_reset();
        test_sra();
        test_back_to_back();
        test_alu_random(40);
        test_mult();
        test_div_mfhi();
        test_divu_zero_stall();
        test_div_overflow();
        test_muldiv_random(8);
        test_alu_random(20);
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d results outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
